// File: rtl/bist_checker.sv
`default_nettype none
// ============================================================================
//  Module      : bist_checker
//  Description : Memory BIST response analyser. Delays the controller's read
//                strobe, expected bit and address by the memory read latency.
//                Compares them with the returned read data. Counts mismatches
//                (saturating) and captures the first failing address and data.
//                Reports done/status when the test finishes.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_checker #(
   parameter int DW     = 8,
   parameter int AW     = 4,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             read_en,
   input  logic             data_bit,
   input  logic [AW-1:0]    addr,
   input  logic             test_end,
   input  logic [DW-1:0]    rd_data,
   output logic             done,
   output logic             status,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [AW-1:0]    fail_adr,
   output logic [DW-1:0]    fail_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Drain counter only has to reach RD_LAT-1 (at most 3).
   localparam int               c_DCW        = 3;
   localparam logic [c_DCW-1:0] c_DRAIN_LAST = c_DCW'(RD_LAT - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_DCW-1:0]   r_drain;

   // Read-tracking pipe: stage RD_LAT-1 lines up with rd_data.
   logic               r_vld [RD_LAT];
   logic               r_exp [RD_LAT];
   logic [AW-1:0]      r_adr [RD_LAT];

   logic               r_first;
   logic               r_done;
   logic               r_status;
   logic [CNT_W-1:0]   r_fail_cnt;
   logic [AW-1:0]      r_fail_adr;
   logic [DW-1:0]      r_fail_data;

   logic               w_clear;
   logic               w_push;
   logic               w_done_entry;
   logic               w_mismatch;
   logic [CNT_W-1:0]   w_cnt_nxt;

   // Next-state logic: start is only honoured when no test is in flight.
   always_comb begin
      w_state_nxt  = r_state;
      w_clear      = 1'b0;
      w_push       = 1'b0;
      w_done_entry = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_clear     = 1'b1;
            end
         end
         S_RUN: begin
            w_push = read_en;
            if (test_end) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_drain == c_DRAIN_LAST) begin
               w_state_nxt  = S_DONE;
               w_done_entry = 1'b1;
            end
         end
         S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_clear     = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Compare the oldest pipe entry against the returned word; saturating count.
   always_comb begin
      w_mismatch = r_vld[RD_LAT-1] && (rd_data != {DW{r_exp[RD_LAT-1]}});
      w_cnt_nxt  = r_fail_cnt;
      if (w_mismatch && (r_fail_cnt != {CNT_W{1'b1}})) begin
         w_cnt_nxt = r_fail_cnt + CNT_W'(1);
      end
   end

   // State register and drain counter (counts cycles spent in DRAIN).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= (r_state == S_DRAIN) ? r_drain + c_DCW'(1) : '0;
      end
   end

   // Shift pipe: one entry per clock, valid only for reads accepted in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            r_vld[i] <= 1'b0;
            r_exp[i] <= 1'b0;
            r_adr[i] <= '0;
         end
      end else begin
         r_vld[0] <= w_push;
         r_exp[0] <= data_bit;
         r_adr[0] <= addr;
         for (int i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_exp[i] <= r_exp[i-1];
            r_adr[i] <= r_adr[i-1];
         end
      end
   end

   // Result capture: counter always, address/data only on the first failure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_first     <= 1'b0;
         r_fail_cnt  <= '0;
         r_fail_adr  <= '0;
         r_fail_data <= '0;
      end else if (w_clear) begin
         r_first     <= 1'b0;
         r_fail_cnt  <= '0;
         r_fail_adr  <= '0;
         r_fail_data <= '0;
      end else if (w_mismatch) begin
         r_fail_cnt <= w_cnt_nxt;
         if (!r_first) begin
            r_first     <= 1'b1;
            r_fail_adr  <= r_adr[RD_LAT-1];
            r_fail_data <= rd_data;
         end
      end
   end

   // done/status: status uses the count including the final compare landing now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done   <= 1'b0;
         r_status <= 1'b0;
      end else if (w_clear) begin
         r_done   <= 1'b0;
         r_status <= 1'b0;
      end else if (w_done_entry) begin
         r_done   <= 1'b1;
         r_status <= (w_cnt_nxt == '0);
      end
   end

   assign done      = r_done;
   assign status    = r_status;
   assign fail_cnt  = r_fail_cnt;
   assign fail_adr  = r_fail_adr;
   assign fail_data = r_fail_data;

endmodule
`default_nettype wire
